variable_clk_five_sec: RTL and testbench

- Programmable clock divider that produces a slow square wave, variableClk, from the system clock.
- The half-period is user_input0 × TICKS_PER_UNIT system clock cycles.
- At 50 MHz with TICKS_PER_UNIT=125000, an input of 1000 gives a 5 s period.
- Drives tempo/LFO-style timing in the synth; user_input0 comes from switches/UI registers.

---
 rtl/variable_clk_five_sec.sv | 73 +++++++
 tb/tb_variable_clk_five_sec.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/variable_clk_five_sec.sv
`default_nettype none
// ============================================================================
// Module   : variable_clk_five_sec
// Brief    : Programmable divider; variableClk toggles every
//            user_input0 * TICKS_PER_UNIT clk cycles. Optional tick output
//            under macro VARCLK_TICK_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module variable_clk_five_sec #(
   parameter int TICKS_PER_UNIT = 125000,
   parameter int CNT_W          = 27
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] user_input0,
`ifdef VARCLK_TICK_OUT_EN
   output logic       tick,
`endif
   output logic       variableClk
);

   localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;
   logic             r_var_clk;
   logic [CNT_W-1:0] w_limit;
   logic [CNT_W-1:0] w_limit_m1;
   logic             w_idle;
   logic             w_terminal;

   // Limit follows the input every cycle; >= comparison makes a shrinking
   // limit fire on the next edge instead of wrapping the counter.
   assign w_limit    = CNT_W'(user_input0) * CNT_W'(TICKS_PER_UNIT);
   assign w_limit_m1 = w_limit - c_one;
   assign w_idle     = (user_input0 == 10'd0);
   assign w_terminal = (r_cnt >= w_limit_m1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_var_clk <= 1'b0;
      end else if (w_idle) begin
         r_cnt     <= '0;
         r_var_clk <= 1'b0;
      end else if (w_terminal) begin
         r_cnt     <= '0;
         r_var_clk <= ~r_var_clk;
      end else begin
         r_cnt     <= r_cnt + c_one;
      end
   end

   assign variableClk = r_var_clk;

`ifdef VARCLK_TICK_OUT_EN
   logic r_tick;

   // Pulse coincides with the edge on which variableClk rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick <= 1'b0;
      end else if (w_idle) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_terminal & ~r_var_clk;
      end
   end

   assign tick = r_tick;
`endif

endmodule
`default_nettype wire

// File: tb/tb_variable_clk_five_sec.sv
`default_nettype none
// ============================================================================
// Module   : tb_variable_clk_five_sec
// Brief    : Directed self-checking bench for variable_clk_five_sec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_variable_clk_five_sec;

   logic       clk;
   logic       reset_n;
   logic [9:0] user_input0;
   logic       variableClk;
`ifdef VARCLK_TICK_OUT_EN
   logic       tick;
`endif

   int vectors;
   int miscompares;
   int toggles;
   logic prev_clk;

   variable_clk_five_sec #(
      .TICKS_PER_UNIT(1),
      .CNT_W         (27)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .user_input0(user_input0),
`ifdef VARCLK_TICK_OUT_EN
      .tick       (tick),
`endif
      .variableClk(variableClk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cnt_now();
      return 32'(dut.r_cnt);
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      user_input0 = 10'd200;
      #12;
      check("reset_var", {31'd0, variableClk}, 32'd0);
      check("reset_cnt", cnt_now(), 32'd0);
`ifdef VARCLK_TICK_OUT_EN
      check("reset_tick", {31'd0, tick}, 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      // L = 200
      step(199);
      check("a_e199_var", {31'd0, variableClk}, 32'd0);
      check("a_e199_cnt", cnt_now(), 32'd199);
      step(1);
      check("a_e200_var", {31'd0, variableClk}, 32'd1);
      check("a_e200_cnt", cnt_now(), 32'd0);
`ifdef VARCLK_TICK_OUT_EN
      check("a_e200_tick", {31'd0, tick}, 32'd1);
`endif
      step(199);
      check("a_e399_var", {31'd0, variableClk}, 32'd1);
      step(1);
      check("a_e400_var", {31'd0, variableClk}, 32'd0);
      check("a_e400_cnt", cnt_now(), 32'd0);

      // L = 25, 400 edges
      user_input0 = 10'd25;
      toggles = 0;
      prev_clk = variableClk;
      for (int k = 1; k <= 400; k++) begin
         step(1);
         check("b_var", {31'd0, variableClk}, 32'((k / 25) & 1));
`ifdef VARCLK_TICK_OUT_EN
         check("b_tick", {31'd0, tick}, 32'((k % 50) == 25));
`endif
         if (variableClk !== prev_clk) toggles++;
         prev_clk = variableClk;
      end
      check("b_toggles", 32'(toggles), 32'd16);
      check("b_end_var", {31'd0, variableClk}, 32'd0);

      // idle
      user_input0 = 10'd0;
      for (int k = 1; k <= 100; k++) begin
         step(1);
         check("c_var", {31'd0, variableClk}, 32'd0);
         check("c_cnt", cnt_now(), 32'd0);
`ifdef VARCLK_TICK_OUT_EN
         check("c_tick", {31'd0, tick}, 32'd0);
`endif
      end

      // restart from idle
      user_input0 = 10'd25;
      for (int k = 1; k <= 60; k++) begin
         step(1);
         check("d_var", {31'd0, variableClk}, 32'((k / 25) & 1));
      end
      check("d_e60_cnt", cnt_now(), 32'd10);

      // shrink limit mid-count
      user_input0 = 10'd200;
      step(90);
      check("e_cnt100", cnt_now(), 32'd100);
      check("e_var_pre", {31'd0, variableClk}, 32'd0);
      user_input0 = 10'd25;
      step(1);
      check("e_shrink_var", {31'd0, variableClk}, 32'd1);
      check("e_shrink_cnt", cnt_now(), 32'd0);
      step(24);
      check("e_hold_var", {31'd0, variableClk}, 32'd1);
      check("e_hold_cnt", cnt_now(), 32'd24);
      step(1);
      check("e_t2_var", {31'd0, variableClk}, 32'd0);
      step(25);
      check("e_t3_var", {31'd0, variableClk}, 32'd1);

      // asynchronous reset while output high
      #2;
      reset_n = 1'b0;
      #1;
      check("f_async_var", {31'd0, variableClk}, 32'd0);
      check("f_async_cnt", cnt_now(), 32'd0);
      user_input0 = 10'd1;
      @(negedge clk);
      check("f_held_var", {31'd0, variableClk}, 32'd0);
      reset_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check("f_div2_var", {31'd0, variableClk}, 32'(k & 1));
`ifdef VARCLK_TICK_OUT_EN
         check("f_div2_tick", {31'd0, tick}, 32'(k & 1));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
